// File: rtl/note_display_tracker_pkg.sv
// Shared constants and slot record layout for the note tracker and the wave display.
package note_display_tracker_pkg;

    localparam int NUM_SLOTS = 8;
    localparam int NOTE_W    = 6;
    localparam int DUR_W     = 6;

    localparam logic [NOTE_W-1:0] REST_ID = 6'd0;

    typedef struct packed {
        logic              valid;
        logic [NOTE_W-1:0] note;
        logic [DUR_W-1:0]  remaining;
    } slot_t;

    // A note is playable only if it is not a rest and has a non-zero length.
    function automatic logic is_playable(input logic [NOTE_W-1:0] note,
                                         input logic [DUR_W-1:0]  dur);
        return (note != REST_ID) && (dur != 6'd0);
    endfunction

endpackage

// File: rtl/note_slot.sv
// One tracked note: storage plus beat countdown; a load overrides the post-beat value.
module note_slot #(
    parameter int NOTE_W = 6,
    parameter int DUR_W  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              beat,
    input  logic              load,
    input  logic [NOTE_W-1:0] load_note,
    input  logic [DUR_W-1:0]  load_dur,
    output logic              valid,
    output logic [NOTE_W-1:0] note,
    output logic              post_valid,
    output logic [DUR_W-1:0]  post_remaining
);

    logic              valid_r;
    logic [NOTE_W-1:0] note_r;
    logic [DUR_W-1:0]  remaining_r;

    logic              post_valid_s;
    logic [NOTE_W-1:0] post_note_s;
    logic [DUR_W-1:0]  post_remaining_s;

    logic              valid_n_s;
    logic [NOTE_W-1:0] note_n_s;
    logic [DUR_W-1:0]  remaining_n_s;

    // State after this edge's beat, before any allocation is applied.
    always_comb begin
        post_valid_s     = valid_r;
        post_note_s      = note_r;
        post_remaining_s = remaining_r;
        if (valid_r && beat) begin
            if (remaining_r == {{(DUR_W-1){1'b0}}, 1'b1}) begin
                post_valid_s     = 1'b0;
                post_note_s      = {NOTE_W{1'b0}};
                post_remaining_s = {DUR_W{1'b0}};
            end else begin
                post_remaining_s = remaining_r - {{(DUR_W-1){1'b0}}, 1'b1};
            end
        end else begin
            post_remaining_s = remaining_r;
        end
    end

    // Allocation or reload lands on top of the decremented state.
    always_comb begin
        valid_n_s     = post_valid_s;
        note_n_s      = post_note_s;
        remaining_n_s = post_remaining_s;
        if (load) begin
            valid_n_s     = 1'b1;
            note_n_s      = load_note;
            remaining_n_s = load_dur;
        end else begin
            valid_n_s     = post_valid_s;
        end
    end

    // Slot register with synchronous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r     <= 1'b0;
            note_r      <= {NOTE_W{1'b0}};
            remaining_r <= {DUR_W{1'b0}};
        end else begin
            valid_r     <= valid_n_s;
            note_r      <= note_n_s;
            remaining_r <= remaining_n_s;
        end
    end

    assign valid          = valid_r;
    assign note           = note_r;
    assign post_valid     = post_valid_s;
    assign post_remaining = post_remaining_s;

endmodule

// File: rtl/note_display_tracker.sv
// Tracks up to NUM_SLOTS sounding notes and publishes them to the wave display,
// updating the display image only during vertical blanking.
module note_display_tracker #(
    parameter int NUM_SLOTS = note_display_tracker_pkg::NUM_SLOTS,
    parameter int NOTE_W    = note_display_tracker_pkg::NOTE_W,
    parameter int DUR_W     = note_display_tracker_pkg::DUR_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        new_note,
    input  logic [NOTE_W-1:0]           note_in,
    input  logic [DUR_W-1:0]            duration_in,
    input  logic                        beat,
    input  logic                        vsync,
    output logic [NUM_SLOTS*NOTE_W-1:0] notes_to_display,
    output logic [3:0]                  active_count,
    output logic                        overflow
);

    import note_display_tracker_pkg::*;

    localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    logic [NUM_SLOTS-1:0] valid_s;
    logic [NUM_SLOTS-1:0] post_valid_s;
    logic [NUM_SLOTS-1:0] load_s;
    logic [NOTE_W-1:0]    note_s         [NUM_SLOTS];
    logic [DUR_W-1:0]     post_remaining_s [NUM_SLOTS];

    logic                 accept_s;
    logic                 hit_s;
    logic [IDX_W-1:0]     hit_idx_s;
    logic                 free_s;
    logic [IDX_W-1:0]     free_idx_s;
    logic [IDX_W-1:0]     evict_idx_s;
    logic [DUR_W-1:0]     evict_min_s;
    logic                 evict_s;
    logic [3:0]           count_n_s;
    logic [NUM_SLOTS*NOTE_W-1:0] packed_s;

    logic [NUM_SLOTS*NOTE_W-1:0] notes_to_display_r;
    logic [3:0]                  active_count_r;
    logic                        overflow_r;

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        note_slot #(
            .NOTE_W (NOTE_W),
            .DUR_W  (DUR_W)
        ) u_slot (
            .clk            (clk),
            .reset          (reset),
            .beat           (beat),
            .load           (load_s[g]),
            .load_note      (note_in),
            .load_dur       (duration_in),
            .valid          (valid_s[g]),
            .note           (note_s[g]),
            .post_valid     (post_valid_s[g]),
            .post_remaining (post_remaining_s[g])
        );
    end

    assign accept_s = new_note && (note_in != REST_ID) && (duration_in != {DUR_W{1'b0}});

    // Match, free-slot and eviction searches all look at the post-beat state.
    always_comb begin
        hit_s       = 1'b0;
        hit_idx_s   = {IDX_W{1'b0}};
        free_s      = 1'b0;
        free_idx_s  = {IDX_W{1'b0}};
        evict_idx_s = {IDX_W{1'b0}};
        evict_min_s = post_remaining_s[0];
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!hit_s && post_valid_s[i] && (note_s[i] == note_in)) begin
                hit_s     = 1'b1;
                hit_idx_s = IDX_W'(i);
            end else begin
                hit_s     = hit_s;
            end
            if (!free_s && !post_valid_s[i]) begin
                free_s     = 1'b1;
                free_idx_s = IDX_W'(i);
            end else begin
                free_s     = free_s;
            end
            // Strict compare keeps the lowest index on ties.
            if (post_remaining_s[i] < evict_min_s) begin
                evict_min_s = post_remaining_s[i];
                evict_idx_s = IDX_W'(i);
            end else begin
                evict_min_s = evict_min_s;
            end
        end
    end

    // Choose which single slot, if any, takes the incoming note.
    always_comb begin
        load_s  = {NUM_SLOTS{1'b0}};
        evict_s = 1'b0;
        if (accept_s) begin
            if (hit_s) begin
                load_s[hit_idx_s] = 1'b1;
            end else if (free_s) begin
                load_s[free_idx_s] = 1'b1;
            end else begin
                load_s[evict_idx_s] = 1'b1;
                evict_s             = 1'b1;
            end
        end else begin
            evict_s = 1'b0;
        end
    end

    // Occupancy after this edge and the display image of the current state.
    always_comb begin
        count_n_s = 4'd0;
        packed_s  = {(NUM_SLOTS*NOTE_W){1'b0}};
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (post_valid_s[i] || load_s[i]) begin
                count_n_s = count_n_s + 4'd1;
            end else begin
                count_n_s = count_n_s;
            end
            if (valid_s[i]) begin
                packed_s[i*NOTE_W +: NOTE_W] = note_s[i];
            end else begin
                packed_s[i*NOTE_W +: NOTE_W] = {NOTE_W{1'b0}};
            end
        end
    end

    // Output registers; the display image only refreshes during blanking.
    always_ff @(posedge clk) begin
        if (reset) begin
            notes_to_display_r <= {(NUM_SLOTS*NOTE_W){1'b0}};
            active_count_r     <= 4'd0;
            overflow_r         <= 1'b0;
        end else begin
            if (!vsync) begin
                notes_to_display_r <= packed_s;
            end else begin
                notes_to_display_r <= notes_to_display_r;
            end
            active_count_r <= count_n_s;
            overflow_r     <= evict_s;
        end
    end

    assign notes_to_display = notes_to_display_r;
    assign active_count     = active_count_r;
    assign overflow         = overflow_r;

endmodule

// File: tb/tb_note_display_tracker.sv
// Directed bench for note_display_tracker with a per-cycle reference model.
module tb_note_display_tracker;

    localparam int NS = 8;
    localparam int NW = 6;
    localparam int DW = 6;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           new_note = 1'b0;
    logic [NW-1:0]  note_in = 6'd0;
    logic [DW-1:0]  duration_in = 6'd0;
    logic           beat = 1'b0;
    logic           vsync = 1'b0;
    logic [NS*NW-1:0] notes_to_display;
    logic [3:0]     active_count;
    logic           overflow;

    int n_checks = 0;
    int n_errors = 0;

    note_display_tracker dut (
        .clk              (clk),
        .reset            (reset),
        .new_note         (new_note),
        .note_in          (note_in),
        .duration_in      (duration_in),
        .beat             (beat),
        .vsync            (vsync),
        .notes_to_display (notes_to_display),
        .active_count     (active_count),
        .overflow         (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    // Reference model: a list of (valid, note, remaining) records.
    bit   mv [NS];
    int   mn [NS];
    int   mr [NS];
    logic [NS*NW-1:0] m_disp;
    int   m_cnt;
    bit   m_ovf;
    bit   m_ready = 1'b0;

    function automatic logic [NS*NW-1:0] pack_model(input bit v[NS], input int n[NS]);
        logic [NS*NW-1:0] p;
        p = '0;
        for (int i = 0; i < NS; i++)
            if (v[i]) p[i*NW +: NW] = n[i][NW-1:0];
        return p;
    endfunction

    always @(posedge clk) begin : model
        bit v[NS];
        int n[NS];
        int r[NS];
        int hit, fre, ev, c;
        bit evf;
        logic [NS*NW-1:0] d;
        if (reset) begin
            for (int i = 0; i < NS; i++) begin v[i] = 0; n[i] = 0; r[i] = 0; end
            d = '0; c = 0; evf = 0;
        end else begin
            d = vsync ? m_disp : pack_model(mv, mn);
            v = mv; n = mn; r = mr;
            if (beat)
                for (int i = 0; i < NS; i++)
                    if (v[i]) begin
                        r[i] = r[i] - 1;
                        if (r[i] == 0) begin v[i] = 0; n[i] = 0; end
                    end
            evf = 0;
            if (new_note && note_in != 0 && duration_in != 0) begin
                hit = -1; fre = -1;
                for (int i = NS-1; i >= 0; i--) begin
                    if (v[i] && n[i] == int'(note_in)) hit = i;
                    if (!v[i]) fre = i;
                end
                if (hit >= 0) r[hit] = int'(duration_in);
                else begin
                    if (fre < 0) begin
                        ev = 0;
                        for (int i = 1; i < NS; i++) if (r[i] < r[ev]) ev = i;
                        fre = ev; evf = 1;
                    end
                    v[fre] = 1; n[fre] = int'(note_in); r[fre] = int'(duration_in);
                end
            end
            c = 0;
            for (int i = 0; i < NS; i++) if (v[i]) c++;
        end
        mv <= v; mn <= n; mr <= r;
        m_disp <= d; m_cnt <= c; m_ovf <= evf;
        if (reset) m_ready <= 1'b1;
    end

    // Compare every cycle once the model has seen a reset.
    always @(negedge clk) begin
        if (m_ready) begin
            check("model_disp",  64'(notes_to_display), 64'(m_disp));
            check("model_count", 64'(active_count),     64'(m_cnt));
            check("model_ovf",   64'(overflow),         64'(m_ovf));
        end
    end

    task automatic send(input int n, input int d, input bit b);
        new_note = 1'b1; note_in = NW'(n); duration_in = DW'(d); beat = b;
        @(negedge clk);
        new_note = 1'b0; note_in = '0; duration_in = '0; beat = 1'b0;
    endtask

    task automatic beats(input int k);
        repeat (k) begin beat = 1'b1; @(negedge clk); beat = 1'b0; end
    endtask

    task automatic idle(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; @(negedge clk); reset = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_disp",  64'(notes_to_display), 64'd0);
        check("reset_count", 64'(active_count),     64'd0);
        check("reset_ovf",   64'(overflow),         64'd0);
        reset = 1'b0;

        // Basic note
        send(12, 3, 0);
        check("basic_count", 64'(active_count), 64'd1);
        idle(1);
        check("basic_disp", 64'(notes_to_display[5:0]), 64'd12);
        beats(3);
        check("basic_count_end", 64'(active_count), 64'd0);
        idle(1);
        check("basic_disp_end", 64'(notes_to_display), 64'd0);

        // Reload keeps a single slot and restarts its countdown
        send(12, 2, 0);
        beats(1);
        send(12, 5, 0);
        check("reload_count", 64'(active_count), 64'd1);
        idle(1);
        check("reload_disp", 64'(notes_to_display), 64'd12);
        beats(4);
        check("reload_alive", 64'(active_count), 64'd1);
        beats(1);
        check("reload_gone", 64'(active_count), 64'd0);

        // Overflow evicts the shortest remaining slot
        do_reset();
        for (int i = 1; i <= 8; i++) send(i, 10 - i, 0);
        check("ovf_full", 64'(active_count), 64'd8);
        send(40, 4, 0);
        check("ovf_pulse", 64'(overflow), 64'd1);
        check("ovf_count", 64'(active_count), 64'd8);
        idle(1);
        check("ovf_one_cycle", 64'(overflow), 64'd0);
        check("ovf_slot7", 64'(notes_to_display[47:42]), 64'd40);
        check("ovf_others", 64'(notes_to_display[41:0]),
              64'({6'd7, 6'd6, 6'd5, 6'd4, 6'd3, 6'd2, 6'd1}));

        // Beat frees slot 0 on the same edge the new note arrives
        do_reset();
        send(50, 1, 0);
        for (int i = 1; i <= 7; i++) send(50 + i, 10, 0);
        send(33, 6, 1);
        check("sim_ovf", 64'(overflow), 64'd0);
        check("sim_count", 64'(active_count), 64'd8);
        idle(1);
        check("sim_slot0", 64'(notes_to_display[5:0]), 64'd33);
        beats(5);
        check("sim_full_dur", 64'(active_count), 64'd8);
        beats(1);
        check("sim_expire", 64'(active_count), 64'd7);

        // Frame hold while the display scans
        do_reset();
        idle(1);
        vsync = 1'b1;
        send(20, 5, 0);
        idle(3);
        check("hold_disp", 64'(notes_to_display), 64'd0);
        vsync = 1'b0;
        idle(1);
        check("hold_release", 64'(notes_to_display[5:0]), 64'd20);

        // Reset mid-frame with five notes active
        do_reset();
        for (int i = 1; i <= 5; i++) send(20 + i, 30, 0);
        idle(1);
        check("mid_count", 64'(active_count), 64'd5);
        vsync = 1'b1; reset = 1'b1;
        @(negedge clk);
        check("mid_rst_disp",  64'(notes_to_display), 64'd0);
        check("mid_rst_count", 64'(active_count),     64'd0);
        reset = 1'b0; vsync = 1'b0;

        // Ignored requests and a note lost under reset
        send(12, 5, 0);
        idle(1);
        send(0, 4, 0);
        send(7, 0, 0);
        check("ign_count", 64'(active_count), 64'd1);
        check("ign_ovf",   64'(overflow),     64'd0);
        idle(1);
        check("ign_disp", 64'(notes_to_display), 64'd12);
        reset = 1'b1;
        send(9, 3, 0);
        reset = 1'b0;
        idle(1);
        check("rst_lost", 64'(active_count), 64'd0);

        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
